// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   ADDRESS_LEN      : width of word addresses / pc
//   INSTRUCTION_LEN  : width of an instruction word
//   fetch_state_e    : FETCH (request outstanding), HOLD (instruction held),
//                      KILL (outstanding request to be discarded)
package fetch_unit_pkg;

  localparam int unsigned ADDRESS_LEN     = 16;
  localparam int unsigned INSTRUCTION_LEN = 32;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    KILL  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word requests to instruction memory, holds the
// returned word for the IF/ID register and handles redirects from later stages.
//
// Optional build macro: IF_PERF_CNT_EN adds saturating 32-bit fetch/stall counters.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   stall               hold from decode (IF/ID write enable is its inverse)
//   branch_taken        redirect request, highest priority
//   branch_target       redirect address
//   imem_req/imem_addr  instruction memory request and word address
//   imem_ready          one-cycle pulse: imem_rdata valid, request complete
//   imem_rdata          fetched word
//   PR0_PC_plus1        address of held instruction plus 1 (0 when no instruction)
//   PR0_instruction     held instruction (0 when no instruction)
//   if_valid            PR0_* carry a real instruction
//   fetch_count         [IF_PERF_CNT_EN] instructions entering HOLD
//   stall_count         [IF_PERF_CNT_EN] HOLD cycles with stall asserted
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDRESS_LEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       branch_taken,
  input  logic [ADDRESS_LEN-1:0]     branch_target,
  output logic                       imem_req,
  output logic [ADDRESS_LEN-1:0]     imem_addr,
  input  logic                       imem_ready,
  input  logic [INSTRUCTION_LEN-1:0] imem_rdata,
  output logic [ADDRESS_LEN-1:0]     PR0_PC_plus1,
  output logic [INSTRUCTION_LEN-1:0] PR0_instruction,
  output logic                       if_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]                fetch_count,
  output logic [31:0]                stall_count
`endif
);

  fetch_state_e               state_q, state_d;
  logic [ADDRESS_LEN-1:0]     pc_q, pc_d;
  logic [ADDRESS_LEN-1:0]     kill_addr_q, kill_addr_d;
  logic [ADDRESS_LEN-1:0]     pc1_q, pc1_d;
  logic [INSTRUCTION_LEN-1:0] instr_q, instr_d;
  // Low during reset and for the first edge after release, so no request is
  // presented while rst is low and the first request appears on that edge.
  logic                       active_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_addr_d = kill_addr_q;
    pc1_d       = pc1_q;
    instr_d     = instr_q;
    unique case (state_q)
      FETCH: begin
        if (branch_taken) begin
          pc_d = branch_target;
          // A request still in flight must be flushed before refetching.
          if (active_q && !imem_ready) begin
            state_d     = KILL;
            kill_addr_d = pc_q;
          end
        end else if (active_q && imem_ready) begin
          state_d = HOLD;
          instr_d = imem_rdata;
          pc1_d   = pc_q + ADDRESS_LEN'(1);
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = FETCH;
        end else if (!stall) begin
          pc_d    = pc_q + ADDRESS_LEN'(1);
          state_d = FETCH;
        end
      end
      KILL: begin
        if (branch_taken) begin
          pc_d = branch_target;
        end else if (imem_ready) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      kill_addr_q <= '0;
      pc1_q       <= '0;
      instr_q     <= '0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_addr_q <= kill_addr_d;
      pc1_q       <= pc1_d;
      instr_q     <= instr_d;
      active_q    <= 1'b1;
    end
  end

  always_comb begin
    imem_req        = active_q && (state_q != HOLD);
    imem_addr       = (state_q == KILL) ? kill_addr_q : pc_q;
    if_valid        = (state_q == HOLD);
    // Bubble matches the IF/ID flush value.
    PR0_PC_plus1    = if_valid ? pc1_q : '0;
    PR0_instruction = if_valid ? instr_q : '0;
  end

`ifdef IF_PERF_CNT_EN
  logic fetch_inc, stall_inc;

  always_comb begin
    fetch_inc = (state_q == FETCH) && (state_d == HOLD);
    stall_inc = (state_q == HOLD) && stall;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (fetch_inc && (fetch_count != '1)) fetch_count <= fetch_count + 32'd1;
      if (stall_inc && (stall_count != '1)) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
